// File: rtl/csr_cmd_regs_if.sv
// csr_cmd_regs_if: MMIO request/response bundle between the host and csr_cmd_regs
interface csr_cmd_regs_if;
  logic        mmio_wr;
  logic        mmio_rd;
  logic [15:0] mmio_addr;
  logic [63:0] mmio_wdata;
  logic [8:0]  mmio_tid;
  logic        mmio_rsp_valid;
  logic [8:0]  mmio_rsp_tid;
  logic [63:0] mmio_rsp_data;
  modport master (
    output mmio_wr, mmio_rd, mmio_addr, mmio_wdata, mmio_tid,
    input  mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data
  );
  modport slave (
    input  mmio_wr, mmio_rd, mmio_addr, mmio_wdata, mmio_tid,
    output mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data
  );
endinterface

// File: rtl/csr_cmd_regs.sv
// csr_cmd_regs: MMIO command registers and GO/ABORT sequencer for the memcpy stage (perf counters under CSR_CMD_PERF_EN)
module csr_cmd_regs #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000,
  parameter logic [63:0] AFU_ID         = 64'h0
) (
  input  logic          clk,
  input  logic          rst_n,
  csr_cmd_regs_if.slave mmio,
  output logic          start,
  output logic          clear,
  output logic [63:0]   destination,
  output logic [63:0]   source,
  output logic [63:0]   mc_num,
  input  logic          done
);
  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;
  state_t      state, state_nxt;
  logic [31:0] run_cnt;
  logic        st_done, st_timeout;
  logic        busy, in_range, ctrl_wr, go, abort, launch, timeout_hit;
  logic        fin, to_evt, kill;
  logic [2:0]  reg_sel;
  logic [63:0] rdata, cycles_rd, cmds_rd;
  logic        unused_addr_bits;
  assign busy             = (state == ARM) || (state == RUN);
  assign in_range         = mmio.mmio_addr[15:6] == 10'd0;
  assign reg_sel          = mmio.mmio_addr[5:3];
  assign unused_addr_bits = ^mmio.mmio_addr[2:0];
  assign ctrl_wr          = mmio.mmio_wr && in_range && (reg_sel == 3'd4);
  assign abort            = ctrl_wr && mmio.mmio_wdata[1];
  assign go               = ctrl_wr && mmio.mmio_wdata[0] && !mmio.mmio_wdata[1];
  assign launch           = go && !busy;
  assign timeout_hit      = (TIMEOUT_CYCLES != 32'd0) && (run_cnt == TIMEOUT_CYCLES - 32'd1);
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // next state plus completion, timeout and abort events
  always_comb begin
    state_nxt = state;
    fin       = 1'b0;
    to_evt    = 1'b0;
    kill      = 1'b0;
    case (state)
      IDLE, DONE: state_nxt = go ? ARM : state;
      ARM: begin
        state_nxt = abort ? IDLE : RUN;
        kill      = abort;
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
          kill      = 1'b1;
        end else if (done) begin
          state_nxt = DONE;
          fin       = 1'b1;
        end else if (timeout_hit) begin
          state_nxt = IDLE;
          to_evt    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
  // registered downstream controls: start follows RUN, clear marks ARM and every abandon
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      start <= 1'b0;
      clear <= 1'b0;
    end else begin
      start <= state_nxt == RUN;
      clear <= (state_nxt == ARM) || kill || to_evt;
    end
  // command words, frozen while a command is in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      destination <= 64'd0;
      source      <= 64'd0;
      mc_num      <= 64'd0;
    end else if (mmio.mmio_wr && in_range && !busy) begin
      destination <= (reg_sel == 3'd1) ? mmio.mmio_wdata : destination;
      source      <= (reg_sel == 3'd2) ? mmio.mmio_wdata : source;
      mc_num      <= (reg_sel == 3'd3) ? mmio.mmio_wdata : mc_num;
    end
  // sticky status flags, cleared by an accepted GO
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_done    <= 1'b0;
      st_timeout <= 1'b0;
    end else begin
      st_done    <= launch ? 1'b0 : (st_done | fin);
      st_timeout <= launch ? 1'b0 : (st_timeout | to_evt);
    end
  // saturating RUN-cycle counter; also drives the timeout so it exists in every build
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) run_cnt <= 32'd0;
    else if (launch) run_cnt <= 32'd0;
    else if (state == RUN && run_cnt != 32'hFFFF_FFFF) run_cnt <= run_cnt + 32'd1;
`ifdef CSR_CMD_PERF_EN
  logic [63:0] cmds;
  // wrapping count of completed commands
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cmds <= 64'd0;
    else cmds <= cmds + {63'd0, fin};
  assign cycles_rd = {32'd0, run_cnt};
  assign cmds_rd   = cmds;
`else
  assign cycles_rd = 64'd0;
  assign cmds_rd   = 64'd0;
`endif
  // read mux over the register map; CTRL and unmapped offsets read 0
  always_comb begin
    rdata = 64'd0;
    if (in_range)
      case (reg_sel)
        3'd0:    rdata = AFU_ID;
        3'd1:    rdata = destination;
        3'd2:    rdata = source;
        3'd3:    rdata = mc_num;
        3'd5:    rdata = {61'd0, st_timeout, st_done, busy};
        3'd6:    rdata = cycles_rd;
        3'd7:    rdata = cmds_rd;
        default: rdata = 64'd0;
      endcase
  end
  // one-cycle read response; sampling before this edge's writes gives pre-write data
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mmio.mmio_rsp_valid <= 1'b0;
      mmio.mmio_rsp_tid   <= 9'd0;
      mmio.mmio_rsp_data  <= 64'd0;
    end else begin
      mmio.mmio_rsp_valid <= mmio.mmio_rd;
      mmio.mmio_rsp_tid   <= mmio.mmio_rd ? mmio.mmio_tid : mmio.mmio_rsp_tid;
      mmio.mmio_rsp_data  <= mmio.mmio_rd ? rdata : mmio.mmio_rsp_data;
    end
endmodule

// File: tb/tb_csr_cmd_regs.sv
// tb_csr_cmd_regs: directed checks of csr_cmd_regs register map, sequencing, timeout and reset
module tb_csr_cmd_regs;
  localparam logic [63:0] AFU = 64'hCAFE_F00D_1234_5678;
`ifdef CSR_CMD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic done = 1'b0;
  logic start, clear, start_t, clear_t;
  logic [63:0] dst, src, num, dst_t, src_t, num_t;
  int errors = 0;
  int checks = 0;
  csr_cmd_regs_if m();
  csr_cmd_regs_if t();
  csr_cmd_regs #(.AFU_ID(AFU)) u_dut (
    .clk(clk), .rst_n(rst_n), .mmio(m), .start(start), .clear(clear),
    .destination(dst), .source(src), .mc_num(num), .done(done)
  );
  csr_cmd_regs #(.TIMEOUT_CYCLES(32'd8), .AFU_ID(AFU)) u_to (
    .clk(clk), .rst_n(rst_n), .mmio(t), .start(start_t), .clear(clear_t),
    .destination(dst_t), .source(src_t), .mc_num(num_t), .done(1'b0)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    m.mmio_wr = 1'b1;
    m.mmio_addr = a;
    m.mmio_wdata = d;
    tick;
    m.mmio_wr = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [15:0] a, input logic [63:0] exp);
    m.mmio_rd = 1'b1;
    m.mmio_addr = a;
    m.mmio_tid = 9'h055;
    tick;
    m.mmio_rd = 1'b0;
    chk({tag, "_valid"}, {63'd0, m.mmio_rsp_valid}, 64'd1);
    chk(tag, m.mmio_rsp_data, exp);
  endtask
  initial begin
    m.mmio_wr = 1'b0; m.mmio_rd = 1'b0; m.mmio_addr = 16'd0; m.mmio_wdata = 64'd0; m.mmio_tid = 9'd0;
    t.mmio_wr = 1'b0; t.mmio_rd = 1'b0; t.mmio_addr = 16'd0; t.mmio_wdata = 64'd0; t.mmio_tid = 9'd0;
    tick;
    tick;
    chk("rst_start", {63'd0, start}, 64'd0);
    chk("rst_clear", {63'd0, clear}, 64'd0);
    chk("rst_dst", dst, 64'd0);
    chk("rst_rsp_valid", {63'd0, m.mmio_rsp_valid}, 64'd0);
    rst_n = 1'b1;
    tick;
    rd("rst_status", 16'h28, 64'd0);
    wr(16'h08, 64'h1000);
    chk("dst_write", dst, 64'h1000);
    wr(16'h10, 64'h2000);
    wr(16'h18, 64'h10);
    wr(16'h20, 64'h1);
    chk("go_clear", {63'd0, clear}, 64'd1);
    chk("go_start_low", {63'd0, start}, 64'd0);
    tick;
    chk("arm_clear_drop", {63'd0, clear}, 64'd0);
    chk("run_start", {63'd0, start}, 64'd1);
    chk("out_dst", dst, 64'h1000);
    chk("out_src", src, 64'h2000);
    chk("out_num", num, 64'h10);
    repeat (19) tick;
    chk("run_start_hold", {63'd0, start}, 64'd1);
    done = 1'b1;
    tick;
    done = 1'b0;
    chk("done_start_drop", {63'd0, start}, 64'd0);
    rd("status_done", 16'h28, 64'h2);
    rd("cycles", 16'h30, PERF ? 64'd20 : 64'd0);
    rd("cmds", 16'h38, PERF ? 64'd1 : 64'd0);
    m.mmio_rd = 1'b1; m.mmio_addr = 16'h00; m.mmio_tid = 9'h01A;
    tick;
    chk("b2b0_valid", {63'd0, m.mmio_rsp_valid}, 64'd1);
    chk("b2b0_data", m.mmio_rsp_data, AFU);
    chk("b2b0_tid", {55'd0, m.mmio_rsp_tid}, 64'h1A);
    m.mmio_addr = 16'h18; m.mmio_tid = 9'h01B;
    tick;
    m.mmio_rd = 1'b0;
    chk("b2b1_valid", {63'd0, m.mmio_rsp_valid}, 64'd1);
    chk("b2b1_data", m.mmio_rsp_data, 64'h10);
    chk("b2b1_tid", {55'd0, m.mmio_rsp_tid}, 64'h1B);
    tick;
    chk("rsp_one_cycle", {63'd0, m.mmio_rsp_valid}, 64'd0);
    wr(16'h20, 64'h1);
    chk("go2_clear", {63'd0, clear}, 64'd1);
    tick;
    chk("go2_start", {63'd0, start}, 64'd1);
    wr(16'h08, 64'hDEAD);
    chk("busy_dst_locked", dst, 64'h1000);
    wr(16'h20, 64'h1);
    chk("busy_go_no_clear", {63'd0, clear}, 64'd0);
    tick;
    chk("busy_go_no_clear2", {63'd0, clear}, 64'd0);
    chk("busy_go_start", {63'd0, start}, 64'd1);
    rd("status_busy", 16'h28, 64'h1);
    wr(16'h20, 64'h2);
    chk("abort_start", {63'd0, start}, 64'd0);
    chk("abort_clear", {63'd0, clear}, 64'd1);
    tick;
    chk("abort_clear_drop", {63'd0, clear}, 64'd0);
    rd("status_abort", 16'h28, 64'h0);
    wr(16'h20, 64'h3);
    chk("go_abort_clear", {63'd0, clear}, 64'd0);
    chk("go_abort_start", {63'd0, start}, 64'd0);
    tick;
    chk("go_abort_start2", {63'd0, start}, 64'd0);
    rd("ctrl_reads0", 16'h20, 64'd0);
    rd("unmapped", 16'h40, 64'd0);
    wr(16'h08, 64'hDEAD);
    chk("idle_dst_write", dst, 64'hDEAD);
    m.mmio_wr = 1'b1; m.mmio_rd = 1'b1; m.mmio_addr = 16'h08; m.mmio_wdata = 64'h5555;
    tick;
    m.mmio_wr = 1'b0; m.mmio_rd = 1'b0;
    chk("rw_pre_value", m.mmio_rsp_data, 64'hDEAD);
    chk("rw_new_dst", dst, 64'h5555);
    t.mmio_wr = 1'b1; t.mmio_addr = 16'h20; t.mmio_wdata = 64'h1;
    tick;
    t.mmio_wr = 1'b0;
    chk("to_go_clear", {63'd0, clear_t}, 64'd1);
    tick;
    chk("to_start", {63'd0, start_t}, 64'd1);
    repeat (7) tick;
    chk("to_run7_start", {63'd0, start_t}, 64'd1);
    chk("to_run7_clear", {63'd0, clear_t}, 64'd0);
    tick;
    chk("to_start_drop", {63'd0, start_t}, 64'd0);
    chk("to_clear", {63'd0, clear_t}, 64'd1);
    tick;
    chk("to_clear_drop", {63'd0, clear_t}, 64'd0);
    t.mmio_rd = 1'b1; t.mmio_addr = 16'h28;
    tick;
    t.mmio_addr = 16'h30;
    chk("to_status", t.mmio_rsp_data, 64'h4);
    tick;
    t.mmio_rd = 1'b0;
    chk("to_cycles", t.mmio_rsp_data, PERF ? 64'd8 : 64'd0);
    wr(16'h20, 64'h1);
    tick;
    chk("rst_run_start", {63'd0, start}, 64'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_start", {63'd0, start}, 64'd0);
    chk("async_rst_dst", dst, 64'd0);
    tick;
    rst_n = 1'b1;
    tick;
    rd("post_rst_dst", 16'h08, 64'd0);
    rd("post_rst_num", 16'h18, 64'd0);
    rd("post_rst_status", 16'h28, 64'd0);
    rd("post_rst_cmds", 16'h38, 64'd0);
    chk("post_rst_start", {63'd0, start}, 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
